// File: rtl/vga_dither_pkg.sv
// Shared widths, timing/pixel structs and the 4x4 Bayer threshold matrix for the VGA dither stage.
package vga_dither_pkg;

  localparam int PIX_IN_W   = 8;
  localparam int PIX_OUT_W  = 4;
  localparam int PIPE_DEPTH = 2;
  localparam int THR_W      = PIX_IN_W - PIX_OUT_W;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } timing_t;

  typedef struct packed {
    logic [PIX_IN_W-1:0] red;
    logic [PIX_IN_W-1:0] green;
    logic [PIX_IN_W-1:0] blue;
  } rgb8_t;

  // Row-major, index {row, column}
  localparam logic [THR_W-1:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  function automatic logic [THR_W-1:0] bayer_thr(input logic [1:0] ix, input logic [1:0] iy);
    return BAYER[{iy, ix}];
  endfunction

endpackage

// File: rtl/vga_dither_4bit_if.sv
// Pixel/timing bundle in (8-bit RGB) and out (4-bit RGB) of the dither stage.
interface vga_dither_4bit_if;
  import vga_dither_pkg::*;

  logic [PIX_IN_W-1:0]  vga_red;
  logic [PIX_IN_W-1:0]  vga_green;
  logic [PIX_IN_W-1:0]  vga_blue;
  logic                 vga_hsync;
  logic                 vga_vsync;
  logic                 vga_de;

  logic [PIX_OUT_W-1:0] vga4_red;
  logic [PIX_OUT_W-1:0] vga4_green;
  logic [PIX_OUT_W-1:0] vga4_blue;
  logic                 vga4_hsync;
  logic                 vga4_vsync;
  logic                 vga4_de;

  modport master (
    output vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, vga_de,
    input  vga4_red, vga4_green, vga4_blue, vga4_hsync, vga4_vsync, vga4_de
  );

  modport slave (
    input  vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, vga_de,
    output vga4_red, vga4_green, vga4_blue, vga4_hsync, vga4_vsync, vga4_de
  );
endinterface

// File: rtl/vga_dither_channel.sv
// Second pipeline stage for one colour: round up when low nibble exceeds T, saturate, blank.
// With VGA_DITHER_EN undefined it registers the plain truncated nibble instead.
module vga_dither_channel
  import vga_dither_pkg::*;
(
  input  logic                 vga_clk,
  input  logic                 vga_rst,
  input  logic [PIX_IN_W-1:0]  pix_i,
  input  logic [THR_W-1:0]     thr_i,
  input  logic                 de_i,
  output logic [PIX_OUT_W-1:0] pix_o
);

  logic [PIX_OUT_W-1:0] hi;
  logic [PIX_OUT_W-1:0] pix_d;
  logic [PIX_OUT_W-1:0] pix_q;

  assign hi = pix_i[PIX_IN_W-1 -: PIX_OUT_W];

`ifdef VGA_DITHER_EN
  logic               round_up;
  logic [PIX_OUT_W:0] sum;

  assign round_up = pix_i[THR_W-1:0] > thr_i;
  assign sum      = {1'b0, hi} + {{PIX_OUT_W{1'b0}}, round_up};
  // A carry can only come from hi == 15, so clamping to all-ones is exact
  assign pix_d    = !de_i ? '0 : (sum[PIX_OUT_W] ? '1 : sum[PIX_OUT_W-1:0]);
`else
  logic unused_low;
  assign unused_low = ^{pix_i[THR_W-1:0], thr_i};
  assign pix_d      = de_i ? hi : '0;
`endif

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) pix_q <= '0;
    else         pix_q <= pix_d;
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/vga_dither_4bit.sv
// 8->4 bit per channel ordered dither with 2-cycle latency on pixel, syncs and de.
// Dithering (position counters, Bayer lookup) is built only when VGA_DITHER_EN is defined.
module vga_dither_4bit
  import vga_dither_pkg::*;
#(
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter bit TEMPORAL  = 1'b1
) (
  input logic              vga_clk,
  input logic              vga_rst,
  vga_dither_4bit_if.slave vga
);

  localparam timing_t TIM_IDLE = '{de: 1'b0, hsync: ~HSYNC_POL, vsync: ~VSYNC_POL};

  timing_t               tim_d;
  timing_t               tim_q [PIPE_DEPTH];
  rgb8_t                 pix_d;
  rgb8_t                 pix_q;
  logic [THR_W-1:0]      thr_s1;
  logic [PIX_OUT_W-1:0]  red4;
  logic [PIX_OUT_W-1:0]  green4;
  logic [PIX_OUT_W-1:0]  blue4;

  assign tim_d = '{de: vga.vga_de, hsync: vga.vga_hsync, vsync: vga.vga_vsync};
  assign pix_d = '{red: vga.vga_red, green: vga.vga_green, blue: vga.vga_blue};

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      pix_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) tim_q[i] <= TIM_IDLE;
    end else begin
      pix_q    <= pix_d;
      tim_q[0] <= tim_d;
      for (int i = 1; i < PIPE_DEPTH; i++) tim_q[i] <= tim_q[i-1];
    end
  end

`ifdef VGA_DITHER_EN
  logic [1:0]       x_d, x_q;
  logic [1:0]       y_d, y_q;
  logic [1:0]       frame_d, frame_q;
  logic [1:0]       ix, iy;
  logic             vs_lead, de_fall;
  logic [THR_W-1:0] thr_d, thr_q;

  // Stage-1 timing register is exactly last cycle's input, so it serves as the edge reference
  always_comb begin
    vs_lead = (vga.vga_vsync == VSYNC_POL) && (tim_q[0].vsync != VSYNC_POL);
    de_fall = tim_q[0].de && !vga.vga_de;
    x_d     = vga.vga_de ? x_q + 2'd1 : 2'd0;
    y_d     = y_q;
    if (vs_lead)      y_d = 2'd0;
    else if (de_fall) y_d = y_q + 2'd1;
    frame_d = vs_lead ? frame_q + 2'd1 : frame_q;
    ix      = TEMPORAL ? (x_q ^ frame_q) : x_q;
    iy      = TEMPORAL ? (y_q ^ {frame_q[0], frame_q[1]}) : y_q;
    thr_d   = bayer_thr(ix, iy);
  end

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      thr_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      thr_q   <= thr_d;
    end
  end

  assign thr_s1 = thr_q;
`else
  logic unused_temporal;
  assign unused_temporal = TEMPORAL;
  assign thr_s1          = '0;
`endif

  vga_dither_channel u_red (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .pix_i   (pix_q.red),
    .thr_i   (thr_s1),
    .de_i    (tim_q[0].de),
    .pix_o   (red4)
  );

  vga_dither_channel u_green (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .pix_i   (pix_q.green),
    .thr_i   (thr_s1),
    .de_i    (tim_q[0].de),
    .pix_o   (green4)
  );

  vga_dither_channel u_blue (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .pix_i   (pix_q.blue),
    .thr_i   (thr_s1),
    .de_i    (tim_q[0].de),
    .pix_o   (blue4)
  );

  assign vga.vga4_red   = red4;
  assign vga.vga4_green = green4;
  assign vga.vga4_blue  = blue4;
  assign vga.vga4_de    = tim_q[PIPE_DEPTH-1].de;
  assign vga.vga4_hsync = tim_q[PIPE_DEPTH-1].hsync;
  assign vga.vga4_vsync = tim_q[PIPE_DEPTH-1].vsync;

endmodule

// File: tb/tb_vga_dither_4bit.sv
// Scoreboard bench for vga_dither_4bit: an independent position/Bayer model predicts each output 2 cycles ahead.
module tb_vga_dither_4bit;

  localparam bit HP = 1'b0;
  localparam bit VP = 1'b0;
  localparam int FRAME_LEN = 27;
  localparam logic [14:0] RST_VEC = {1'b0, ~HP, ~VP, 12'h000};
  localparam logic [3:0] BAYER_REF [16] = '{
    4'd0, 4'd8, 4'd2, 4'd10, 4'd12, 4'd4, 4'd14, 4'd6,
    4'd3, 4'd11, 4'd1, 4'd9, 4'd15, 4'd7, 4'd13, 4'd5
  };

  logic vga_clk = 1'b0;
  logic vga_rst;

  vga_dither_4bit_if vif ();

  vga_dither_4bit #(
    .HSYNC_POL (HP),
    .VSYNC_POL (VP),
    .TEMPORAL  (1'b1)
  ) dut (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .vga     (vif)
  );

  always #5 vga_clk = ~vga_clk;

  logic [14:0] sb [$];
  int total = 0;
  int bad   = 0;
  logic [1:0] mx, my, mf;
  logic m_de_prev, m_vs_prev;

  function automatic logic [14:0] obs();
    return {vif.vga4_de, vif.vga4_hsync, vif.vga4_vsync, vif.vga4_red, vif.vga4_green, vif.vga4_blue};
  endfunction

  function automatic logic [3:0] expc(input logic [7:0] v, input logic [3:0] t);
`ifdef VGA_DITHER_EN
    if ((v[3:0] > t) && (v[7:4] != 4'hF)) return v[7:4] + 4'd1;
    return v[7:4];
`else
    return v[7:4] | (t & 4'h0);
`endif
  endfunction

  // {de, hsync, vsync} for cycle c of a frame: 2 vsync cycles, 1 gap, 4 lines of 4 pixels + 2 blank
  function automatic logic [2:0] frame_tim(input int c);
    int k;
    if (c < 2)  return {1'b0, ~HP, VP};
    if (c == 2) return {1'b0, ~HP, ~VP};
    k = (c - 3) % 6;
    return {(k < 4), ((k == 4) ? HP : ~HP), ~VP};
  endfunction

  task automatic idle_inputs();
    vif.vga_red   = 8'h00;
    vif.vga_green = 8'h00;
    vif.vga_blue  = 8'h00;
    vif.vga_de    = 1'b0;
    vif.vga_hsync = ~HP;
    vif.vga_vsync = ~VP;
  endtask

  task automatic start_after_reset();
    idle_inputs();
    sb.delete();
    mx = 2'd0; my = 2'd0; mf = 2'd0;
    m_de_prev = 1'b0; m_vs_prev = ~VP;
    @(negedge vga_clk);
    vga_rst = 1'b0;
    sb.push_back(RST_VEC);
    sb.push_back(RST_VEC);
  endtask

  task automatic apply(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic de, input logic hs, input logic vs);
    logic [1:0] ix, iy;
    logic [3:0] t;
    logic vs_lead, de_fall;
    @(negedge vga_clk);
    vif.vga_red = r; vif.vga_green = g; vif.vga_blue = b;
    vif.vga_de = de; vif.vga_hsync = hs; vif.vga_vsync = vs;
    ix = mx ^ mf;
    iy = my ^ {mf[0], mf[1]};
    t  = BAYER_REF[{iy, ix}];
    sb.push_back({de, hs, vs, (de ? {expc(r, t), expc(g, t), expc(b, t)} : 12'h000)});
    vs_lead = (vs == VP) && (m_vs_prev != VP);
    de_fall = m_de_prev && !de;
    mx = de ? mx + 2'd1 : 2'd0;
    if (vs_lead)      my = 2'd0;
    else if (de_fall) my = my + 2'd1;
    if (vs_lead)      mf = mf + 2'd1;
    m_de_prev = de;
    m_vs_prev = vs;
  endtask

  task automatic test_reset();
    vga_rst = 1'b1;
    idle_inputs();
    #12;
    total++;
    if (obs() !== RST_VEC) begin
      bad++; $display("FAIL reset_initial got=%h want=%h", obs(), RST_VEC);
    end
    repeat (3) @(negedge vga_clk);
    total++;
    if (obs() !== RST_VEC) begin
      bad++; $display("FAIL reset_held got=%h want=%h", obs(), RST_VEC);
    end
    start_after_reset();
  endtask

  task automatic test_const_tile();
    logic [14:0] exp_v;
    logic [2:0] tm;
    for (int c = 0; c < 2 * FRAME_LEN; c++) begin
      tm = frame_tim(c % FRAME_LEN);
      apply(8'h88, 8'h88, 8'h88, tm[2], tm[1], tm[0]);
      exp_v = sb.pop_front(); total++;
      if (obs() !== exp_v) begin
        bad++; $display("FAIL const88 c=%0d got=%h want=%h", c, obs(), exp_v);
      end
    end
  endtask

  task automatic test_extremes();
    logic [14:0] exp_v;
    logic [2:0] tm;
    logic [7:0] vals [4];
    vals = '{8'hFF, 8'hF0, 8'h00, 8'h0F};
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < FRAME_LEN; c++) begin
        tm = frame_tim(c);
        apply(vals[f], vals[(f + 1) % 4], vals[(f + 2) % 4], tm[2], tm[1], tm[0]);
        exp_v = sb.pop_front(); total++;
        if (obs() !== exp_v) begin
          bad++; $display("FAIL extremes f=%0d c=%0d got=%h want=%h", f, c, obs(), exp_v);
        end
      end
    end
  endtask

  task automatic test_temporal();
    logic [14:0] exp_v;
    logic [2:0] tm;
    int nines;
    int nines_exp;
    nines = 0;
`ifdef VGA_DITHER_EN
    nines_exp = 16;
`else
    nines_exp = 0;
`endif
    for (int c = 0; c < 4 * FRAME_LEN; c++) begin
      tm = frame_tim(c % FRAME_LEN);
      apply(8'h84, 8'h84, 8'h84, tm[2], tm[1], tm[0]);
      exp_v = sb.pop_front(); total++;
      if (obs() !== exp_v) begin
        bad++; $display("FAIL temporal c=%0d got=%h want=%h", c, obs(), exp_v);
      end
      if (vif.vga4_de && vif.vga4_red == 4'd9) nines++;
    end
    total++;
    if (nines !== nines_exp) begin
      bad++; $display("FAIL temporal_nines got=%0d want=%0d", nines, nines_exp);
    end
  endtask

  task automatic test_sync_pattern();
    logic [14:0] exp_v;
    logic [2:0] pat [24];
    pat = '{3'b111, 3'b111, 3'b101, 3'b011, 3'b001, 3'b111, 3'b110, 3'b000,
            3'b011, 3'b111, 3'b111, 3'b111, 3'b010, 3'b100, 3'b111, 3'b011,
            3'b110, 3'b101, 3'b000, 3'b111, 3'b111, 3'b011, 3'b011, 3'b111};
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < 24; c++) begin
        apply(8'($urandom), 8'($urandom), 8'($urandom), pat[c][2], pat[c][1], pat[c][0]);
        exp_v = sb.pop_front(); total++;
        if (obs() !== exp_v) begin
          bad++; $display("FAIL syncpat c=%0d got=%h want=%h", c, obs(), exp_v);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [14:0] exp_v;
    logic [2:0] tm;
    for (int c = 0; c < 3 * FRAME_LEN; c++) begin
      tm = frame_tim(c % FRAME_LEN);
      apply(8'($urandom), 8'($urandom), 8'($urandom), tm[2], tm[1], tm[0]);
      exp_v = sb.pop_front(); total++;
      if (obs() !== exp_v) begin
        bad++; $display("FAIL random c=%0d got=%h want=%h", c, obs(), exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] exp_v;
    logic [2:0] tm;
    for (int c = 0; c < 14; c++) begin
      tm = frame_tim(c);
      apply(8'($urandom), 8'($urandom), 8'($urandom), tm[2], tm[1], tm[0]);
      exp_v = sb.pop_front(); total++;
      if (obs() !== exp_v) begin
        bad++; $display("FAIL pre_reset c=%0d got=%h want=%h", c, obs(), exp_v);
      end
    end
    #2 vga_rst = 1'b1;
    #1;
    total++;
    if (obs() !== RST_VEC) begin
      bad++; $display("FAIL async_reset got=%h want=%h", obs(), RST_VEC);
    end
    start_after_reset();
    // Resume mid-frame without a vsync: counters restart from 0
    for (int c = 3; c < 2 * FRAME_LEN; c++) begin
      tm = frame_tim(c % FRAME_LEN);
      apply(8'($urandom), 8'($urandom), 8'($urandom), tm[2], tm[1], tm[0]);
      exp_v = sb.pop_front(); total++;
      if (obs() !== exp_v) begin
        bad++; $display("FAIL post_reset c=%0d got=%h want=%h", c, obs(), exp_v);
      end
    end
  endtask

  task automatic test_flush();
    logic [14:0] exp_v;
    for (int c = 0; c < 2; c++) begin
      apply(8'h00, 8'h00, 8'h00, 1'b0, ~HP, ~VP);
      exp_v = sb.pop_front(); total++;
      if (obs() !== exp_v) begin
        bad++; $display("FAIL flush c=%0d got=%h want=%h", c, obs(), exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_const_tile();
    test_extremes();
    test_temporal();
    test_sync_pattern();
    test_random();
    test_async_reset();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_dither_4bit.md
# vga_dither_4bit

Ordered-dither stage that converts the 8-bit-per-channel RGB pixel stream produced by the VGA/DVI controller into the 4-bit-per-channel stream that drives the resistor-ladder VGA connector. It replaces plain truncation to `[7:4]` and reduces banding. It sits between the controller outputs and the VGA output IOB flip-flops, in the `vga_clk` domain. Sync and data-enable are delayed to match pixel latency.

## Interface
Parameters:
- `HSYNC_POL`, default 0: active level of `vga_hsync`.
- `VSYNC_POL`, default 0: active level of `vga_vsync`.
- `TEMPORAL`, default 1: when 1, the dither pattern is offset by a 2-bit frame counter. When 0, the pattern is static.

Ports:
- `vga_clk`, in, 1: pixel clock. This is the only clock.
- `vga_rst`, in, 1: reset, asynchronous and active-high.
- `vga_red`, `vga_green`, `vga_blue`, in, 8 each: input pixel.
- `vga_hsync`, `vga_vsync`, `vga_de`, in, 1 each: input timing.
- `vga4_red`, `vga4_green`, `vga4_blue`, out, 4 each: dithered pixel.
- `vga4_hsync`, `vga4_vsync`, `vga4_de`, out, 1 each: timing delayed to match the pixel.

## Operation
- Position tracking, on the input side:
  - `x[1:0]` increments on every cycle with `vga_de`=1 and clears on every cycle with `vga_de`=0.
  - `y[1:0]` increments on each falling edge of `vga_de`.
  - `y` clears on the vsync leading edge, i.e. the transition to `VSYNC_POL`.
  - `frame[1:0]` increments on the vsync leading edge.
- A pixel uses the `x`, `y` and `frame` values held in the cycle it is presented, before any update in that cycle.
- Threshold index: `ix = x ^ (TEMPORAL ? frame : 0)`, `iy = y ^ (TEMPORAL ? {frame[0],frame[1]} : 0)`.
- The threshold `T` is Bayer 4x4 row-major, indexed by `[iy][ix]`:
  - row 0: 0, 8, 2, 10
  - row 1: 12, 4, 14, 6
  - row 2: 3, 11, 1, 9
  - row 3: 15, 7, 13, 5
- Per channel: `out = in[7:4] + (in[3:0] > T)`, saturating at 15.
  - A low nibble of 0 never rounds up.
  - An input of 255 gives 15.
- When `vga_de`=0 at the input, the output pixel is forced to 0. Sync is passed through delayed.
- All three channels use the same `T` in a given cycle.

## Timing
- Fixed latency of 2 `vga_clk` cycles from input to output for pixel, hsync, vsync and de. Stages:
  - Stage 1: register inputs and look up `T`.
  - Stage 2: compare, add and saturate.
- There is no handshake and no stall. The block accepts one pixel every cycle, unconditionally.
- Reset values:
  - Pixel outputs are 0 and `vga4_de` is 0.
  - `vga4_hsync` = `~HSYNC_POL` and `vga4_vsync` = `~VSYNC_POL`, i.e. inactive.
  - `x`, `y` and `frame` are 0.
- Reset released mid-frame: counters start from 0. The pattern is misaligned until the next vsync leading edge; this is accepted.
- Counter wrap-around: `x` and `y` wrap modulo 4 and `frame` wraps modulo 4, with no other effect.
- A vsync leading edge coinciding with a `vga_de` falling edge: the `y` clear takes priority, so `y`=0.

## Configuration
- Macro `VGA_DITHER_EN`.
- Defined: dithering behaves as described above.
- Undefined: output is `in[7:4]`, with the counters and threshold lookup removed. The 2-cycle latency, the de blanking and the reset values are unchanged, so downstream timing does not depend on the macro.

## Structure
- Shared package `vga_dither_pkg` holds:
  - The Bayer matrix as a constant of 16 x 4-bit entries.
  - Localparams for pixel input width (8), output width (4) and pipeline depth (2).
- Sub-module `vga_dither_channel`: takes an 8-bit input, `T` and de, and performs the stage-2 compare, add and saturate. It is instantiated three times, once per colour.

## Test plan
- Reset asserted mid-stream → all outputs take their reset values within the same cycle. This covers the asynchronous reset.
- Constant input 0x88 on all channels over a full 4x4 tile, with `TEMPORAL`=0 → `out` = 8 where `T`≥8 and 9 where `T`<8. That gives eight 8s and eight 9s per tile, in positions matching the matrix.
- Input 0xFF and 0xF0 → always 15. Input 0x00 and 0x0F → 0, except 0x0F gives 1 where `T`<15.
- Toggle `vga_de` and the syncs with a known pattern → the outputs reproduce it exactly 2 cycles later, and the pixel is 0 in every cycle where the input de was low.
- Four frames at constant 0x84 with `TEMPORAL`=1 → the position of each 9 in the tile shifts every frame. Across the 4 frames, each pixel reads 9 exactly once on average over the tile (4 of 16 per frame).
- Build without `VGA_DITHER_EN`, random input → `out` == delayed `in[7:4]` in every cycle with de high.
